regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: RegfileWriteArbiter

---
 rtl/regfile_write_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares one register-file write port between requesters,
// with an optional clear sweep enabled by `define REGFILE_WRITE_ARBITER_CLEAR_EN.
module regfile_write_arbiter #(
  parameter int unsigned DTYPE = 8,
  parameter int unsigned NREGS = 4,
  parameter int unsigned NREQ  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req$000_call,
  input  logic [$clog2(NREGS)-1:0] req$000_addr,
  input  logic [DTYPE-1:0]         req$000_data,
  output logic                     req$000_rdy,
  input  logic                     req$001_call,
  input  logic [$clog2(NREGS)-1:0] req$001_addr,
  input  logic [DTYPE-1:0]         req$001_data,
  output logic                     req$001_rdy,
  input  logic                     clear_call,
  output logic                     clear_rdy,
  output logic                     busy,
  output logic                     wr_call,
  output logic [$clog2(NREGS)-1:0] wr_addr,
  output logic [DTYPE-1:0]         wr_data
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // The requester port list is fixed at two; the register count must be a power of two.
  if (NREQ != 2) begin : g_nreq_chk
    $error("regfile_write_arbiter: NREQ must be 2 to match the requester ports");
  end
  if ((NREGS < 2) || ((NREGS & (NREGS - 1)) != 0)) begin : g_nregs_chk
    $error("regfile_write_arbiter: NREGS must be a power of two >= 2");
  end

  logic [NREQ-1:0]  call;
  logic [AW-1:0]    addr [NREQ];
  logic [DTYPE-1:0] data [NREQ];

  assign call[0] = req$000_call;
  assign call[1] = req$001_call;
  assign addr[0] = req$000_addr;
  assign addr[1] = req$001_addr;
  assign data[0] = req$000_data;
  assign data[1] = req$001_data;

  logic [PW-1:0]   prio_q, prio_d;
  logic [PW-1:0]   gnt_idx;
  logic            found;
  int unsigned     rr_idx;
  logic [NREQ-1:0] rdy_vec;

  logic            arb_en;
  logic            sweep_wr;
  logic [AW-1:0]   sweep_addr;

  // First calling requester in cyclic order starting at prio.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    rr_idx  = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      rr_idx = (32'(prio_q) + k) % NREQ;
      if (!found && call[PW'(rr_idx)]) begin
        found   = 1'b1;
        gnt_idx = PW'(rr_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q <= '0;
    end else begin
      prio_q <= prio_d;
    end
  end

`ifdef REGFILE_WRITE_ARBITER_CLEAR_EN
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep control; a clear accepted alongside a grant starts sweeping on the next cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    arb_en     = 1'b0;
    clear_rdy  = 1'b0;
    busy       = 1'b0;
    sweep_wr   = 1'b0;
    sweep_addr = cnt_q;
    case (state_q)
      IDLE: begin
        arb_en    = reset;
        clear_rdy = reset;
        if (clear_call && reset) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        busy     = reset;
        sweep_wr = reset;
        cnt_d    = AW'(cnt_q + 1'b1);
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
`else
  logic unused_clear_call;
  assign unused_clear_call = clear_call;

  always_comb begin
    arb_en     = reset;
    clear_rdy  = 1'b0;
    busy       = 1'b0;
    sweep_wr   = 1'b0;
    sweep_addr = '0;
  end
`endif

  // Write-port mux: sweep writes take the port, otherwise the granted requester does.
  always_comb begin
    rdy_vec = '0;
    wr_call = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    prio_d  = prio_q;
    if (sweep_wr) begin
      wr_call = 1'b1;
      wr_addr = sweep_addr;
    end else if (arb_en && found) begin
      rdy_vec[gnt_idx] = 1'b1;
      wr_call          = 1'b1;
      wr_addr          = addr[gnt_idx];
      wr_data          = data[gnt_idx];
      prio_d           = (gnt_idx == PW'(NREQ - 1)) ? '0 : PW'(gnt_idx + 1'b1);
    end
  end

  assign req$000_rdy = rdy_vec[0];
  assign req$001_rdy = rdy_vec[1];

endmodule
